spi_master_tx: RTL

SPI_MASTER_TX -- requirements
Module: spi_master_tx

---
 rtl/spi_pkg.sv | 15 +
 rtl/spi_master_tx_if.sv | 24 ++
 rtl/spi_clk_gen.sv | 37 +++
 rtl/spi_master_tx.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI master transmitter.
package spi_pkg;

  localparam int CLK_DIV_MIN = 2;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    SETUP,
    HIGH,
    LOW,
    GUARD
  } spi_state_e;

endpackage

// File: rtl/spi_master_tx_if.sv
// Host-side handshake bundle of spi_master_tx: burst request, byte stream in, byte stream out, status.
interface spi_master_tx_if;

  logic       start;
  logic [7:0] len;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       busy;
  logic       done;

  modport master (
    output start, len, tx_data, tx_valid,
    input  tx_ready, rx_data, rx_valid, busy, done
  );

  modport slave (
    input  start, len, tx_data, tx_valid,
    output tx_ready, rx_data, rx_valid, busy, done
  );

endinterface

// File: rtl/spi_clk_gen.sv
// Half-period counter: while enabled, phase_tick_o pulses on the last cycle of every CLK_DIV-cycle phase.
module spi_clk_gen
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  output logic phase_tick_o
);

  // Out-of-range divisors are clamped so the counter can never stall at zero.
  localparam int              DIV  = (CLK_DIV < CLK_DIV_MIN) ? CLK_DIV_MIN : CLK_DIV;
  localparam logic [7:0]      LAST = 8'(DIV - 1);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  assign phase_tick_o = en_i && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + 8'd1;
    if (!en_i || phase_tick_o) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/spi_master_tx.sv
// SPI mode-0 burst master: streams len bytes MSB first, CS guard time between bursts.
// Optional MISO capture is compiled in with `define SPI_MASTER_RX_EN.
module spi_master_tx
  import spi_pkg::*;
#(
  parameter int CLK_DIV  = 4,
  parameter int CS_GUARD = 2
) (
  input  logic         clk,
  input  logic         rst,
  spi_master_tx_if.slave bus,
  output logic         SPI_CLK,
  output logic         SPI_MOSI,
  input  logic         SPI_MISO,
  output logic         SPI_CS
);

  localparam int         GUARD_N    = (CS_GUARD < 1) ? 1 : CS_GUARD;
  localparam logic [7:0] GUARD_LAST = 8'(GUARD_N - 1);

  spi_state_e state_q;
  logic       cs_q;
  logic       sclk_q;
  logic       mosi_q;
  logic       tx_ready_q;
  logic       done_q;
  logic       busy_q;
  logic [6:0] tx_sr_q;
  logic [2:0] bit_q;
  logic [7:0] byte_q;
  logic [7:0] guard_q;

  logic phase_en;
  logic phase_tick;

  assign phase_en = (state_q == SETUP) || (state_q == HIGH) || (state_q == LOW);

  spi_clk_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_clk_gen (
    .clk         (clk),
    .rst         (rst),
    .en_i        (phase_en),
    .phase_tick_o(phase_tick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cs_q       <= 1'b1;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      tx_ready_q <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      tx_sr_q    <= '0;
      bit_q      <= '0;
      byte_q     <= '0;
      guard_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            if (bus.len != 8'd0) begin
              byte_q     <= bus.len;
              cs_q       <= 1'b0;
              tx_ready_q <= 1'b1;
              busy_q     <= 1'b1;
              state_q    <= FETCH;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        FETCH: begin
          if (bus.tx_valid) begin
            tx_sr_q    <= bus.tx_data[6:0];
            mosi_q     <= bus.tx_data[7];
            tx_ready_q <= 1'b0;
            bit_q      <= '0;
            state_q    <= SETUP;
          end
        end
        SETUP, LOW: begin
          if (phase_tick) begin
            sclk_q  <= 1'b1;
            state_q <= HIGH;
          end
        end
        HIGH: begin
          if (phase_tick) begin
            sclk_q <= 1'b0;
            if (bit_q == 3'd7) begin
              byte_q <= byte_q - 8'd1;
              if (byte_q == 8'd1) begin
                cs_q    <= 1'b1;
                mosi_q  <= 1'b0;
                guard_q <= '0;
                done_q  <= (GUARD_LAST == 8'd0);
                state_q <= GUARD;
              end else begin
                tx_ready_q <= 1'b1;
                state_q    <= FETCH;
              end
            end else begin
              bit_q   <= bit_q + 3'd1;
              mosi_q  <= tx_sr_q[6];
              tx_sr_q <= {tx_sr_q[5:0], 1'b0};
              state_q <= LOW;
            end
          end
        end
        GUARD: begin
          // done is registered one cycle ahead so it lands on the final guard cycle.
          if (guard_q == GUARD_LAST) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            guard_q <= guard_q + 8'd1;
            done_q  <= ((guard_q + 8'd1) == GUARD_LAST);
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

`ifdef SPI_MASTER_RX_EN
  logic [7:0] rx_sr_q;
  logic [7:0] rx_data_q;
  logic       rx_valid_q;

  // MISO is taken on the same clk edge that raises SPI_CLK.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_sr_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      if (((state_q == SETUP) || (state_q == LOW)) && phase_tick) begin
        rx_sr_q <= {rx_sr_q[6:0], SPI_MISO};
      end
      if ((state_q == HIGH) && phase_tick && (bit_q == 3'd7)) begin
        rx_data_q  <= rx_sr_q;
        rx_valid_q <= 1'b1;
      end
    end
  end

  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = rx_valid_q;
`else
  logic unused_miso;
  assign unused_miso  = SPI_MISO;
  assign bus.rx_data  = 8'h00;
  assign bus.rx_valid = 1'b0;
`endif

  assign bus.tx_ready = tx_ready_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign SPI_CLK      = sclk_q;
  assign SPI_MOSI     = mosi_q;
  assign SPI_CS       = cs_q;

endmodule
